mem_ctrl_icache: RTL

//   Byte-serial RAM controller arbitrating one instruction-fetch port and one load/store port onto an 8-bit RAM bus.

---
 rtl/mem_ctrl_icache.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl_icache.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_ctrl_icache                                        |
// | Description : Byte-serial RAM controller arbitrating an instruction  |
// |               fetch port and a load/store port onto an 8-bit RAM     |
// |               bus, with a direct-mapped one-word-per-line icache.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mem_ctrl_icache #(
  parameter int ADDR_W   = 32,
  parameter int IC_IDX_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_data,
  output logic              if_hit,
  input  logic              mm_req,
  input  logic              mm_we,
  input  logic [1:0]        mm_size,
  input  logic [ADDR_W-1:0] mm_addr,
  input  logic [31:0]       mm_wdata,
  output logic [31:0]       mm_rdata,
  output logic              mm_ack,
  input  logic              ic_flush,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr
);

  localparam int LINES = 2 ** IC_IDX_W;
  localparam int TAG_W = ADDR_W - IC_IDX_W - 2;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HIT  = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;      // index of the byte currently on the bus
  logic [1:0]        last_q, last_d;    // index of the final byte (N-1)
  logic              is_mm_q, is_mm_d;
  logic              we_q, we_d;
  logic              fill_q, fill_d;    // fetch may fill its line at DONE
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       data_q, data_d;    // bytes gathered so far
  logic [31:0]       if_hold_q, if_hold_d;
  logic [31:0]       mm_hold_q, mm_hold_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_wr_q, ram_wr_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q [LINES];
  logic [31:0]       word_q [LINES];

  logic [IC_IDX_W-1:0] w_if_idx, w_lo_idx, w_hi_idx;
  logic [ADDR_W-1:0]   w_end_addr;
  logic                w_if_hit;
  logic [1:0]          w_mm_last;
  logic [31:0]         w_done_word;
  logic                fill_en;

  assign w_if_idx   = if_addr[IC_IDX_W+1:2];
  assign w_if_hit   = (if_addr[1:0] == 2'b00) && valid_q[w_if_idx] &&
                      (tag_q[w_if_idx] == if_addr[ADDR_W-1:IC_IDX_W+2]);
  assign w_mm_last  = (mm_size == 2'd0) ? 2'd0 : (mm_size == 2'd1) ? 2'd1 : 2'd3;
  assign w_end_addr = addr_q + ADDR_W'(last_q);
  assign w_lo_idx   = addr_q[IC_IDX_W+1:2];
  assign w_hi_idx   = w_end_addr[IC_IDX_W+1:2];

  // Final read byte arrives on ram_din during DONE, so merge it combinationally
  always_comb begin
    w_done_word = data_q;
    w_done_word[{last_q, 3'b000} +: 8] = ram_din;
  end

  // State register and datapath flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      last_q     <= 2'd0;
      is_mm_q    <= 1'b0;
      we_q       <= 1'b0;
      fill_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_q     <= '0;
      if_hold_q  <= '0;
      mm_hold_q  <= '0;
      ram_addr_q <= '0;
      ram_wr_q   <= 1'b0;
      ram_dout_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      is_mm_q    <= is_mm_d;
      we_q       <= we_d;
      fill_q     <= fill_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      data_q     <= data_d;
      if_hold_q  <= if_hold_d;
      mm_hold_q  <= mm_hold_d;
      ram_addr_q <= ram_addr_d;
      ram_wr_q   <= ram_wr_d;
      ram_dout_q <= ram_dout_d;
      valid_q    <= valid_d;
    end
  end

  // Tag/word storage carries no reset; only the valid bits qualify it
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[w_lo_idx]  <= addr_q[ADDR_W-1:IC_IDX_W+2];
      word_q[w_lo_idx] <= w_done_word;
    end
  end

  // Next-state logic: arbitration in IDLE, byte counting in RD/WR
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 2'd0;
        if (mm_req)      state_d = mm_we ? S_WR : S_RD;
        else if (if_req) state_d = w_if_hit ? S_HIT : S_RD;
      end
      S_HIT:  state_d = S_IDLE;
      S_RD, S_WR: begin
        if (cnt_q == last_q) state_d = S_DONE;
        else                 cnt_d   = cnt_q + 2'd1;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: bus drive, byte capture, response muxing
  always_comb begin
    last_d     = last_q;
    is_mm_d    = is_mm_q;
    we_d       = we_q;
    fill_d     = fill_q & ~ic_flush;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    data_d     = data_q;
    if_hold_d  = if_hold_q;
    mm_hold_d  = mm_hold_q;
    ram_addr_d = ram_addr_q;
    ram_wr_d   = 1'b0;
    ram_dout_d = ram_dout_q;
    case (state_q)
      S_IDLE: begin
        data_d = '0;
        if (mm_req) begin
          is_mm_d    = 1'b1;
          we_d       = mm_we;
          last_d     = w_mm_last;
          fill_d     = 1'b0;
          addr_d     = mm_addr;
          wdata_d    = mm_wdata;
          ram_addr_d = mm_addr;
          ram_wr_d   = mm_we;
          ram_dout_d = mm_wdata[7:0];
        end else if (if_req) begin
          is_mm_d = 1'b0;
          we_d    = 1'b0;
          last_d  = 2'd3;
          addr_d  = if_addr;
          if (w_if_hit) begin
            data_d = word_q[w_if_idx];
            fill_d = 1'b0;
          end else begin
            fill_d     = (if_addr[1:0] == 2'b00) && !ic_flush;
            ram_addr_d = if_addr;
          end
        end
      end
      S_RD: begin
        if (cnt_q != 2'd0) data_d[{cnt_q - 2'd1, 3'b000} +: 8] = ram_din;
        if (cnt_q != last_q) ram_addr_d = addr_q + ADDR_W'(cnt_q) + ADDR_W'(1);
      end
      S_WR: begin
        if (cnt_q != last_q) begin
          ram_wr_d   = 1'b1;
          ram_addr_d = addr_q + ADDR_W'(cnt_q) + ADDR_W'(1);
          ram_dout_d = wdata_q[{cnt_q + 2'd1, 3'b000} +: 8];
        end
      end
      S_HIT:  if_hold_d = data_q;
      S_DONE: begin
        if (!we_q) begin
          if (is_mm_q) mm_hold_d = w_done_word;
          else         if_hold_d = w_done_word;
        end
      end
      default: ;
    endcase

    if_ack   = (state_q == S_HIT) || ((state_q == S_DONE) && !is_mm_q);
    if_hit   = (state_q == S_HIT);
    mm_ack   = (state_q == S_DONE) && is_mm_q;
    if_data  = (state_q == S_HIT) ? data_q :
               (if_ack ? w_done_word : if_hold_q);
    mm_rdata = (mm_ack && !we_q) ? w_done_word : mm_hold_q;
    ram_addr = ram_addr_q;
    ram_wr   = ram_wr_q;
    ram_dout = ram_dout_q;
  end

  // Cache valid bits: fill on fetch-miss completion, store invalidate, flush wins
  always_comb begin
    valid_d = valid_q;
    fill_en = 1'b0;
    if (state_q == S_DONE) begin
      if (we_q) begin
        if (valid_q[w_lo_idx] && (tag_q[w_lo_idx] == addr_q[ADDR_W-1:IC_IDX_W+2]))
          valid_d[w_lo_idx] = 1'b0;
        if (valid_q[w_hi_idx] && (tag_q[w_hi_idx] == w_end_addr[ADDR_W-1:IC_IDX_W+2]))
          valid_d[w_hi_idx] = 1'b0;
      end else if (!is_mm_q && fill_q) begin
        valid_d[w_lo_idx] = 1'b1;
        fill_en           = 1'b1;
      end
    end
    if (ic_flush) begin
      valid_d = '0;
      fill_en = 1'b0;
    end
  end

endmodule
`default_nettype wire
